// File: rtl/phase_ctrl_gen.sv
// Phase accumulator command generator: a sample-rate divider issues advance commands,
// and a one-deep holding register buffers host increments for issue as load commands.
module phase_ctrl_gen #(
    parameter int unsigned SAMPLE_DIV = 1134,
    parameter logic [3:0]  CTRL_ADV   = 4'b0001,
    parameter logic [3:0]  CTRL_LOAD  = 4'b1001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        inc_valid,
    input  logic [15:0] inc_data,
    output logic        inc_ready,
    output logic [3:0]  phase_ctrl,
    output logic [15:0] phase_data,
    output logic        tick
);

    typedef enum logic [1:0] {IDLE, PEND, DRAIN} state_t;

    localparam logic [10:0] DIV_LAST = 11'(SAMPLE_DIV - 1);

    state_t      state, state_nxt;
    logic [10:0] div_cnt;
    logic [15:0] hold_data;
    logic        hold_full, hold_full_nxt;
    logic        load_q;
    logic        load_go;
    logic        adv_due;
    logic        handshake;

    assign adv_due   = enable && (div_cnt == DIV_LAST);
    assign handshake = inc_valid && inc_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (!enable) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PEND holds until the load it requested is actually on phase_ctrl (load_q),
    // so DRAIN always follows the visible load cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (handshake) state_nxt = PEND;
            PEND:    if (load_q) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_go       = (state == PEND) && !load_q && !adv_due;
        hold_full_nxt = hold_full;
        if (handshake) begin
            hold_full_nxt = 1'b1;
        end else if (state == DRAIN) begin
            hold_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            inc_ready <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            hold_full <= hold_full_nxt;
            inc_ready <= !hold_full_nxt;
            load_q    <= load_go;
            if (handshake) begin
                hold_data <= inc_data;
            end
        end
    end

    // Advance always wins the command slot; load_go already excludes advance cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_ctrl <= '0;
            phase_data <= '0;
            tick       <= 1'b0;
        end else begin
            tick <= adv_due;
            if (adv_due) begin
                phase_ctrl <= CTRL_ADV;
            end else if (load_go) begin
                phase_ctrl <= CTRL_LOAD;
                phase_data <= hold_data;
            end else begin
                phase_ctrl <= '0;
            end
        end
    end

endmodule
